uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receive stage; consumes the line driven by the transmitter.
//  Oversamples rx, finds the start bit, and samples 8 data bits LSB-first at mid-bit.
//  Then samples an optional parity bit and one stop bit.
//  Presents the byte, the 11-bit frame image and error flags to the display/consumer logic.
//  Uses a pending/acknowledge handshake.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD        9_600       line rate, bit/s
//  OVERSAMPLE  16          sample ticks per bit; even, >=8
//  PARITY_EN   1           1 = parity bit present between data and stop
//  PARITY_ODD  0           0 = even parity, 1 = odd (ignored if PARITY_EN=0)
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-high; clears all state
//  rx              in   1   serial line, idle high, asynchronous to clk
//  read_ack        in   1   consumer has taken data; clears data_pending and overrun
//  data            out  8   last received byte, held until next valid frame
//  frame           out  11  {stop, parity, data[7:0], start}; parity=0 when PARITY_EN=0
//  data_valid      out  1   1-clk pulse when a frame completes (errored frames too)
//  data_pending    out  1   set with data_valid, cleared by read_ack
//  parity_error    out  1   1-clk pulse with data_valid if parity mismatched
//  framing_error   out  1   1-clk pulse with data_valid if stop sampled low
//  overrun         out  1   sticky; frame completed while data_pending=1
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; synchroniser flops preset to 1 (idle line).
//  rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
//  Tick: 1-clk pulse every DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)) clocks.
//   Default DIV = 326.
//   Divider restarts at 0 on IDLE->START so sampling phase aligns to the falling edge.
//  FSM states and transitions:
//   IDLE: sync rx=0 -> START, tick count cleared.
//   START: after OVERSAMPLE/2 ticks, resample.
//    High -> IDLE (glitch, no output).
//    Low -> DATA, bit index 0.
//   DATA: every OVERSAMPLE ticks, shift sample into bit[idx], LSB first.
//    After idx 7 -> PARITY if PARITY_EN, else STOP.
//   PARITY: sample after OVERSAMPLE ticks; error = sample != (^data ^ PARITY_ODD).
//   STOP: sample after OVERSAMPLE ticks.
//    Next clk: update data/frame, pulse data_valid and error flags.
//    Then -> IDLE immediately; there is no wait for the end of the stop bit.
//    A low stop also -> IDLE; a new falling edge is needed for the next frame.
//  Latency: data_valid = 1 clk after the stop-bit mid-sample, plus 2 clk synchroniser delay.
//  Handshake:
//   data_valid sets data_pending.
//   read_ack clears data_pending and overrun.
//   Same-cycle data_valid and read_ack: data_pending stays 1, overrun unchanged.
//   Completion while pending and no read_ack: overrun <= 1; data is overwritten with the new byte.
//  Reset asserted mid-frame: frame discarded, no data_valid; reception restarts on the next falling edge.
//  Counters: tick divider is ceil(log2(DIV)) bits; sample counter is log2(OVERSAMPLE) bits; wrap is never relied on.
// STRUCTURE
//  Shared package uart_pkg:
//   FSM state encoding: IDLE, START, DATA, PARITY, STOP.
//   FRAME_W=11, DATA_W=8.
//   DIV computation function; shared with the transmitter.
//  Sub-module uart_baud_tick: parameterised divider with sync restart input and tick output.
//   Reused by the transmitter at OVERSAMPLE=1.
//  Top: synchroniser, FSM, shift register, parity check, handshake/flag registers.
// TESTING (DIV overridden to 4 for sim; bit period = 4*OVERSAMPLE clk)
//  1. Send 0x55, even parity bit 0, stop 1.
//     -> data=0x55, frame=11'b1_0_01010101_0, one data_valid pulse, no errors, pending=1.
//  2. Send 0xA3 with parity bit 1 (wrong, even).
//     -> data=0xA3, parity_error pulses with data_valid, framing_error=0.
//  3. Send 0x0F with stop bit 0.
//     -> framing_error pulse, data=0x0F; the next good frame of 0x3C is received correctly.
//  4. Drive rx low for OVERSAMPLE/4 ticks, then high.
//     -> no data_valid; FSM back in IDLE; no flags change.
//  5. Send 0x11 then 0x22 with no read_ack.
//     -> overrun=1, data=0x22; read_ack -> pending=0, overrun=0.
//     Also: read_ack coincident with data_valid -> pending=1.
//  6. Assert reset mid-DATA of 0x99.
//     -> all outputs 0 at once, no data_valid; the following 0x5A is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, frame geometry and the
// baud-divider calculation used by both the receiver and the transmitter.
package uart_pkg;

  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int den;
    den = baud * oversample;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running tick generator: one-clock pulse every DIV clocks. A restart
// forces the count back to zero so the tick phase follows an external event.
module uart_baud_tick #(
  parameter int DIV = 326
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST) && !restart_i;

  // Count 0..DIV-1, zeroing on restart or at the end of each period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (restart_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: synchronises rx, locks onto a start-bit falling edge,
// samples data/parity/stop at mid-bit and hands results over with a
// pending/acknowledge handshake and sticky overrun.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter int DIV        = calc_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic               read_ack,
  output logic [DATA_W-1:0]  data,
  output logic [FRAME_W-1:0] frame,
  output logic               data_valid,
  output logic               data_pending,
  output logic               parity_error,
  output logic               framing_error,
  output logic               overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e         state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic              par_err_q, par_err_d;
  logic              restart, tick, done;

  logic [DATA_W-1:0]  data_q;
  logic [FRAME_W-1:0] frame_q;
  logic               valid_q, pending_q, perr_q, ferr_q, overrun_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection;
  // all preset to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // FSM next-state, sample counting and bit capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_err_d = par_err_q;
    restart   = 1'b0;
    done      = 1'b0;
    if (state_q != IDLE && tick) cnt_d = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        // Edge rather than level, so a low stop bit cannot retrigger.
        if (!rx_sync_q && rx_prev_q) begin
          state_d   = START;
          cnt_d     = '0;
          restart   = 1'b1;
          par_bit_d = 1'b0;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (tick && cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && cnt_q == FULL_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick && cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_sync_q;
          par_err_d = rx_sync_q != ((^shift_q) ^ PARITY_ODD);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick && cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
    end
  end

  // Result, flag pulses and handshake. An ack seen during the valid pulse
  // is taken as stale and does not clear the freshly delivered byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= done;
      perr_q  <= done & par_err_q;
      ferr_q  <= done & ~rx_sync_q;
      if (done) begin
        data_q    <= shift_q;
        frame_q   <= {rx_sync_q, par_bit_q, shift_q, 1'b0};
        pending_q <= 1'b1;
        if (pending_q && !read_ack) overrun_q <= 1'b1;
      end else if (read_ack && !valid_q) begin
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign data          = data_q;
  assign frame         = frame_q;
  assign data_valid    = valid_q;
  assign data_pending  = pending_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a shortened divider (DIV=4).
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int OS  = 16;
  localparam int BIT = 4 * OS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        read_ack = 1'b0;
  logic [7:0]  data;
  logic [10:0] frame;
  logic        data_valid, data_pending, parity_error, framing_error, overrun;

  int checks = 0;
  int errors = 0;
  int dv_total = 0;
  int dv_base;
  logic [7:0]  last_data = '0;
  logic [10:0] last_frame = '0;
  logic        last_pe = 1'b0, last_fe = 1'b0;

  uart_receiver #(
    .OVERSAMPLE (OS),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (1'b0),
    .DIV        (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .read_ack      (read_ack),
    .data          (data),
    .frame         (frame),
    .data_valid    (data_valid),
    .data_pending  (data_pending),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Capture every valid pulse and the flags/data presented with it.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_total   <= dv_total + 1;
      last_data  <= data;
      last_frame <= frame;
      last_pe    <= parity_error;
      last_fe    <= framing_error;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  // One whole frame; optionally raises read_ack while data_valid is high.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic ack_on_valid);
    dv_base = dv_total;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    rx = stop;
    for (int i = 0; i < BIT; i++) begin
      @(negedge clk);
      read_ack = ack_on_valid & data_valid;
    end
    read_ack = 1'b0;
    rx = 1'b1;
    repeat (8) @(negedge clk);
    $display("frame byte=%02h par=%0d stop=%0d -> valid=%0d data=%02h pe=%0d fe=%0d pend=%0d ovr=%0d",
             b, par, stop, dv_total - dv_base, data, last_pe, last_fe, data_pending, overrun);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_frame", frame, 0);
    check("rst_valid", data_valid, 0);
    check("rst_pending", data_pending, 0);
    check("rst_flags", {parity_error, framing_error, overrun}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: clean 0x55
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    check("t1_count", dv_total - dv_base, 1);
    check("t1_data", last_data, 8'h55);
    check("t1_frame", last_frame, 11'b1_0_01010101_0);
    check("t1_pe", last_pe, 0);
    check("t1_fe", last_fe, 0);
    check("t1_pending", data_pending, 1);
    check("t1_held", data, 8'h55);
    ack_pulse();
    check("t1_ack_pending", data_pending, 0);

    // 2: 0xA3 with wrong (odd) parity bit
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    check("t2_count", dv_total - dv_base, 1);
    check("t2_data", last_data, 8'hA3);
    check("t2_frame", last_frame, 11'b1_1_10100011_0);
    check("t2_pe", last_pe, 1);
    check("t2_fe", last_fe, 0);
    ack_pulse();

    // 3: 0x0F with low stop, then good 0x3C
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    check("t3_count", dv_total - dv_base, 1);
    check("t3_data", last_data, 8'h0F);
    check("t3_fe", last_fe, 1);
    check("t3_pe", last_pe, 0);
    check("t3_frame", last_frame, 11'b0_0_00001111_0);
    ack_pulse();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("t3b_count", dv_total - dv_base, 1);
    check("t3b_data", last_data, 8'h3C);
    check("t3b_fe", last_fe, 0);
    check("t3b_pe", last_pe, 0);
    ack_pulse();

    // 4: short glitch
    dv_base = dv_total;
    rx = 1'b0;
    repeat (OS) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    $display("glitch -> valid=%0d state=%0d", dv_total - dv_base, dut.state_q);
    check("t4_count", dv_total - dv_base, 0);
    check("t4_state", dut.state_q, IDLE);
    check("t4_pending", data_pending, 0);
    check("t4_data", data, 8'h3C);

    // 5: overrun, ack, then ack coincident with valid
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    check("t5_ovr_first", overrun, 0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("t5_overrun", overrun, 1);
    check("t5_data", data, 8'h22);
    check("t5_pending", data_pending, 1);
    ack_pulse();
    check("t5_ack_pending", data_pending, 0);
    check("t5_ack_overrun", overrun, 0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    check("t5_coinc_count", dv_total - dv_base, 1);
    check("t5_coinc_pending", data_pending, 1);
    check("t5_coinc_overrun", overrun, 0);

    // 6: reset during data of 0x99, then 0x5A
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(((i == 0) || (i == 3)) ? 1'b1 : 1'b0);
    reset = 1'b1;
    #1;
    check("t6_data", data, 0);
    check("t6_frame", frame, 0);
    check("t6_pending", data_pending, 0);
    check("t6_flags", {data_valid, parity_error, framing_error, overrun}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dv_base = dv_total;
    repeat (150) @(negedge clk);
    check("t6_no_valid", dv_total - dv_base, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check("t6_count", dv_total - dv_base, 1);
    check("t6_rx_data", last_data, 8'h5A);
    check("t6_rx_frame", last_frame, 11'b1_0_01011010_0);
    check("t6_errs", {last_pe, last_fe, overrun}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
